video_timing: RTL and testbench

Parametrised raster timing generator producing pixel clock-enable, sync, display-enable and scaled pixel coordinates for the console's video pipeline. Successor to the fixed 320x240 sync generator plus divided-clock pair: everything runs on one clock with a clock-enable, and the porch/sync geometry, sync polarity, pixel divider and logical-pixel scaling are all parameters. Sits between the board clock and `chip`, which consumes `hpos_o`/`vpos_o`/`de_o` on `pix_ce_o`.

---
 rtl/video_pkg.sv | 35 +++
 rtl/video_timing_if.sv | 30 +++
 rtl/pixel_ce_gen.sv | 37 +++
 rtl/video_timing.sv | 130 +++++++++++++
 tb/tb_video_timing.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared raster geometry types and preset modes for the video timing generator.
package video_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } mode_t;

    localparam mode_t VGA_640x480 = '{
        h: '{640, 16, 96, 48},
        v: '{480, 10, 2, 33}
    };

    localparam mode_t QVGA_320x240 = '{
        h: '{320, 8, 48, 24},
        v: '{240, 4, 3, 15}
    };

    function automatic int total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // Position ports need at least one bit even for degenerate geometries.
    function automatic int posw(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle driven by video_timing and consumed by the pixel pipeline.
interface video_timing_if #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 1
);
    localparam int HPW = video_pkg::posw(H_ACTIVE >> SCALE_SHIFT);
    localparam int VPW = video_pkg::posw(V_ACTIVE >> SCALE_SHIFT);

    logic           pix_ce_o;
    logic           hsync_o;
    logic           vsync_o;
    logic           de_o;
    logic           vblank_o;
    logic [HPW-1:0] hpos_o;
    logic [VPW-1:0] vpos_o;
    logic           line_start_o;
    logic           frame_start_o;

    modport master (
        output pix_ce_o, hsync_o, vsync_o, de_o, vblank_o,
        output hpos_o, vpos_o, line_start_o, frame_start_o
    );

    modport slave (
        input pix_ce_o, hsync_o, vsync_o, de_o, vblank_o,
        input hpos_o, vpos_o, line_start_o, frame_start_o
    );

endinterface

// File: rtl/pixel_ce_gen.sv
// Pixel prescaler: turns the system clock into a gated pixel step and a
// one-clock pix_ce pulse aligned with the freshly registered outputs.
module pixel_ce_gen #(
    parameter int PIX_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic step_o,
    output logic pix_ce_o
);
    localparam int CW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_ce;
    logic          w_step;

    assign w_step   = en_i && (r_cnt == LAST);
    assign step_o   = w_step;
    assign pix_ce_o = r_ce & en_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_ce <= w_step;
            if (w_step) begin
                r_cnt <= '0;
            end else if (en_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_timing.sv
// Parametrised raster timing generator: h/v counters stepped by pixel_ce_gen,
// with every output a registered decode of the post-step position.
module video_timing #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIX_DIV     = 4,
    parameter int SCALE_SHIFT = 1,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    video_timing_if.master vif
);
    import video_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW = $clog2(H_TOTAL + 1);
    localparam int VCW = $clog2(V_TOTAL + 1);
    localparam int HPW = posw(H_ACTIVE >> SCALE_SHIFT);
    localparam int VPW = posw(V_ACTIVE >> SCALE_SHIFT);

    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SS   = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] H_SE   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SS   = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] V_SE   = VCW'(V_ACTIVE + V_FP + V_SYNC);

    if (PIX_DIV < 1) begin : g_bad_div
        $error("video_timing: PIX_DIV must be >= 1");
    end
    if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0 ||
        (V_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
        $error("video_timing: active size not a multiple of the scale");
    end

    logic           w_step;
    logic           w_pix_ce;
    logic [HCW-1:0] w_h_nxt;
    logic [VCW-1:0] w_v_nxt;
    logic           w_h_wrap;
    logic           w_de;
    logic           w_vact;

    logic [HCW-1:0] r_h;
    logic [VCW-1:0] r_v;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_de;
    logic           r_vblank;
    logic [HPW-1:0] r_hpos;
    logic [VPW-1:0] r_vpos;
    logic           r_ls;
    logic           r_fs;

    pixel_ce_gen #(
        .PIX_DIV (PIX_DIV)
    ) u_ce (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i),
        .step_o   (w_step),
        .pix_ce_o (w_pix_ce)
    );

    always_comb begin
        w_h_wrap = (r_h == H_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_h + 1'b1;
        w_v_nxt  = r_v;
        if (w_h_wrap) begin
            w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end
        w_vact = (w_v_nxt < V_ACT);
        w_de   = (w_h_nxt < H_ACT) && w_vact;
    end

    // Reset parks on the last back-porch pixel so the first step opens a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_h      <= H_LAST;
            r_v      <= V_LAST;
            r_hsync  <= ~HSYNC_POL;
            r_vsync  <= ~VSYNC_POL;
            r_de     <= 1'b0;
            r_vblank <= 1'b1;
            r_hpos   <= '0;
            r_vpos   <= '0;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
        end else if (w_step) begin
            r_h      <= w_h_nxt;
            r_v      <= w_v_nxt;
            r_hsync  <= (w_h_nxt >= H_SS && w_h_nxt < H_SE) ?
                        HSYNC_POL : ~HSYNC_POL;
            r_vsync  <= (w_v_nxt >= V_SS && w_v_nxt < V_SE) ?
                        VSYNC_POL : ~VSYNC_POL;
            r_de     <= w_de;
            r_vblank <= ~w_vact;
            r_hpos   <= w_de ? HPW'(w_h_nxt >> SCALE_SHIFT) : '0;
            r_vpos   <= w_vact ? VPW'(w_v_nxt >> SCALE_SHIFT) : '0;
            r_ls     <= (w_h_nxt == '0) && w_vact;
            r_fs     <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end else begin
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
        end
    end

    assign vif.pix_ce_o      = w_pix_ce;
    assign vif.hsync_o       = r_hsync;
    assign vif.vsync_o       = r_vsync;
    assign vif.de_o          = r_de;
    assign vif.vblank_o      = r_vblank;
    assign vif.hpos_o        = r_hpos;
    assign vif.vpos_o        = r_vpos;
    assign vif.line_start_o  = r_ls & en_i;
    assign vif.frame_start_o = r_fs & en_i;

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench: two small-geometry instances against an arithmetic
// raster model, plus literal frame/line/sync expectations.
module tb_video_timing;
    import video_pkg::*;

    typedef struct packed {
        logic       ce;
        logic       hs;
        logic       vs;
        logic       de;
        logic       vb;
        logic       ls;
        logic       fs;
        logic [7:0] hp;
        logic [7:0] vp;
    } obs_t;

    localparam mode_t MG = '{h: '{8, 2, 3, 1}, v: '{4, 1, 2, 1}};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en_a  = 1'b1;
    logic en_b  = 1'b1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    video_timing_if #(.H_ACTIVE(8), .V_ACTIVE(4), .SCALE_SHIFT(0)) vif_a ();
    video_timing_if #(.H_ACTIVE(8), .V_ACTIVE(4), .SCALE_SHIFT(1)) vif_b ();

    video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(3), .SCALE_SHIFT(0), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en_a),
        .vif    (vif_a)
    );

    video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(1), .SCALE_SHIFT(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en_b),
        .vif    (vif_b)
    );

    obs_t oa, ob;
    always_comb begin
        oa    = '0;
        oa.ce = vif_a.pix_ce_o;
        oa.hs = vif_a.hsync_o;
        oa.vs = vif_a.vsync_o;
        oa.de = vif_a.de_o;
        oa.vb = vif_a.vblank_o;
        oa.ls = vif_a.line_start_o;
        oa.fs = vif_a.frame_start_o;
        oa.hp = 8'(vif_a.hpos_o);
        oa.vp = 8'(vif_a.vpos_o);
        ob    = '0;
        ob.ce = vif_b.pix_ce_o;
        ob.hs = vif_b.hsync_o;
        ob.vs = vif_b.vsync_o;
        ob.de = vif_b.de_o;
        ob.vb = vif_b.vblank_o;
        ob.ls = vif_b.line_start_o;
        ob.fs = vif_b.frame_start_o;
        ob.hp = 8'(vif_b.hpos_o);
        ob.vp = 8'(vif_b.vpos_o);
    end

    // Model state: enabled clocks since reset, and whether the last edge stepped.
    int ka, kb;
    bit sa, sb;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ka = 0; kb = 0; sa = 1'b0; sb = 1'b0;
        end else begin
            sa = en_a && (ka % 3 == 2);
            sb = en_b;
            if (en_a) ka++;
            if (en_b) kb++;
        end
    end

    function automatic obs_t expv(int k, bit s, bit en, int div, mode_t m,
                                  int sh, bit hpol, bit vpol);
        obs_t e;
        int n, ht, vt, p, h, v, hss, vss;
        e    = '0;
        e.hs = ~hpol;
        e.vs = ~vpol;
        e.vb = 1'b1;
        n    = k / div;
        if (n == 0) return e;
        ht   = total(m.h);
        vt   = total(m.v);
        p    = (n - 1) % (ht * vt);
        h    = p % ht;
        v    = p / ht;
        hss  = m.h.active + m.h.fp;
        vss  = m.v.active + m.v.fp;
        e.ce = s && en;
        e.hs = (h >= hss && h < hss + m.h.sync) ? hpol : ~hpol;
        e.vs = (v >= vss && v < vss + m.v.sync) ? vpol : ~vpol;
        e.de = (h < m.h.active) && (v < m.v.active);
        e.vb = (v >= m.v.active);
        e.hp = e.de ? 8'(h >> sh) : 8'd0;
        e.vp = (v < m.v.active) ? 8'(v >> sh) : 8'd0;
        e.ls = e.ce && h == 0 && v < m.v.active;
        e.fs = e.ce && p == 0;
        return e;
    endfunction

    task automatic cmp(string nm, obs_t a, obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, a, e);
        end
    endtask

    task automatic lit(string nm, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("modelA", oa, expv(ka, sa, en_a, 3, MG, 0, 1'b0, 1'b0));
            cmp("modelB", ob, expv(kb, sb, en_b, 1, MG, 1, 1'b1, 1'b1));
        end
    end

    // Runs from reset release through one full frame of dut_a, gathering stats.
    task automatic run_frame(output int f1, output int f2, output int nde,
                             output int nls, output int nhs, output int nvs,
                             output int bbad);
        int hx[8];
        int vx[8];
        hx = '{0, 0, 1, 1, 2, 2, 3, 3};
        vx = '{0, 0, 1, 1, 0, 0, 0, 0};
        f1 = -1; f2 = -1;
        nde = 0; nls = 0; nhs = 0; nvs = 0; bbad = 0;
        rst_n = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            #1;
            if (vif_a.frame_start_o) begin
                if (f1 < 0) f1 = c;
                else if (f2 < 0) f2 = c;
            end
            if (f1 > 0 && f2 < 0 && vif_a.pix_ce_o) begin
                nde += int'(vif_a.de_o);
                nls += int'(vif_a.line_start_o);
                nhs += int'(!vif_a.hsync_o);
                nvs += int'(!vif_a.vsync_o);
            end
            if (!vif_b.pix_ce_o) bbad++;
            if (c <= 8 && int'(vif_b.hpos_o) != hx[c-1]) bbad++;
            if (c > 8 && c <= 14 && vif_b.hpos_o != '0) bbad++;
            if (c >= 11 && c <= 13 && vif_b.hsync_o != 1'b1) bbad++;
            if ((c == 10 || c == 14) && vif_b.hsync_o != 1'b0) bbad++;
            if ((c - 1) % 14 == 0 && c <= 8 * 14 &&
                int'(vif_b.vpos_o) != vx[(c-1)/14]) bbad++;
            if (f2 > 0 && c >= f2 + 2) break;
        end
    endtask

    task automatic frame_checks(string tag);
        int f1, f2, nde, nls, nhs, nvs, bbad;
        run_frame(f1, f2, nde, nls, nhs, nvs, bbad);
        lit({tag, "_fs_first"}, f1, 3);
        lit({tag, "_frame_period"}, f2 - f1, 336);
        lit({tag, "_de_steps"}, nde, 32);
        lit({tag, "_line_starts"}, nls, 4);
        lit({tag, "_hsync_low"}, nhs, 24);
        lit({tag, "_vsync_low"}, nvs, 28);
        lit({tag, "_B_pattern"}, bbad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int found, bad, got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        #1;
        lit("rstA_hsync", int'(vif_a.hsync_o), 1);
        lit("rstB_hsync", int'(vif_b.hsync_o), 0);
        lit("rstA_vblank", int'(vif_a.vblank_o), 1);
        lit("rstA_de", int'(vif_a.de_o), 0);
        frame_checks("p1");

        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (vif_a.pix_ce_o && vif_a.de_o && vif_a.hpos_o == 3'd5) begin
                found = 1;
                break;
            end
        end
        lit("find_h5", found, 1);
        en_a = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (vif_a.pix_ce_o || vif_a.hpos_o != 3'd5 || !vif_a.de_o) bad++;
        end
        lit("freeze", bad, 0);
        en_a = 1'b1;
        got = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (vif_a.pix_ce_o) begin
                got = int'(vif_a.hpos_o);
                break;
            end
        end
        lit("resume_h6", got, 6);

        repeat (3000) begin
            @(negedge clk);
            #1;
            en_a = ($urandom_range(0, 3) != 0);
            en_b = ($urandom_range(0, 3) != 0);
        end
        en_a = 1'b1;
        en_b = 1'b1;

        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (!vif_a.hsync_o) begin
                found = 1;
                break;
            end
        end
        lit("find_sync", found, 1);
        #2 rst_n = 1'b0;
        #1;
        lit("arst_hsync", int'(vif_a.hsync_o), 1);
        lit("arst_vsync", int'(vif_a.vsync_o), 1);
        lit("arst_vblank", int'(vif_a.vblank_o), 1);
        lit("arst_pix_ce", int'(vif_a.pix_ce_o), 0);
        lit("arst_B_hsync", int'(vif_b.hsync_o), 0);
        @(negedge clk);
        #1;
        frame_checks("p4");

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
